// File: rtl/i2c_mon_pkg.sv
// i2c_mon_pkg
// Shared definitions for the passive I2C bus monitor: the FSM state
// encoding, the bit counter width, and the index of the ACK slot within a
// 9-clock byte frame.
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_BITS = 2'd1,
        DATA_BITS = 2'd2
    } mon_state_t;

    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] ACK_BIT_IDX = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
// Brings one raw, asynchronous I2C line into the clk domain and optionally
// deglitches it.
//   clk       in  system clock
//   reset     in  synchronous, active-high reset (line reads as idle-high)
//   raw_line  in  raw scl or sda level, asynchronous to clk
//   filt_line out synchronised (and, with the filter built in, debounced) level
// Build option: I2C_MON_GLITCH_FILTER_EN adds a counter that only accepts a
// new level after FILT_LEN consecutive identical synchronised samples.
// Without it the output is the synchroniser output and FILT_LEN is unused.
module i2c_line_filter #(
    parameter int FILT_LEN = 3,
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_line,
    output logic filt_line
);

    logic [SYNC_LEN-1:0] sync_q;
    logic                synced;

    // Reject parameter values the structure below cannot support.
    if (FILT_LEN < 1 || SYNC_LEN < 2) begin : g_param_check
        $error("i2c_line_filter: FILT_LEN must be >= 1 and SYNC_LEN >= 2");
    end

    // Synchroniser chain; resets to 1 so the bus reads as idle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], raw_line};
        end
    end

    assign synced = sync_q[SYNC_LEN-1];

`ifdef I2C_MON_GLITCH_FILTER_EN
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Count how long the synchronised level has disagreed with the accepted
    // level; any agreement restarts the count, so short pulses never land.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (synced == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign filt_line = filt_q;
`else
    assign filt_line = synced;
`endif

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor
// Passive I2C sniffer. Detects START/STOP, deserialises each byte plus its
// ACK slot and offers it on a single-entry valid/ready byte stream. It never
// drives the bus.
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   scl, sda   in  raw I2C lines, asynchronous to clk
//   byte_data  out captured byte (MSB first on the wire)
//   byte_addr  out byte is the first after START / repeated START
//   byte_nack  out ACK-slot level (1 = NACK)
//   byte_valid out byte_* fields valid, held until accepted
//   byte_ready in  consumer accepts when byte_valid && byte_ready
//   start_det  out one-cycle pulse on START or repeated START
//   stop_det   out one-cycle pulse on STOP
//   overrun    out sticky: a completed byte was dropped
// Build option: I2C_MON_GLITCH_FILTER_EN enables the per-line glitch filter
// inside i2c_line_filter.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] byte_data,
    output logic       byte_addr,
    output logic       byte_nack,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       overrun
);

    logic fscl;
    logic fsda;
    logic fscl_d;
    logic fsda_d;
    logic scl_rise;
    logic start_cond;
    logic stop_cond;

    mon_state_t           state_q;
    mon_state_t           state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic                 shift_en;
    logic                 ack_en;

    logic [7:0] sreg_q;
    logic       pend_q;
    logic [7:0] pend_data_q;
    logic       pend_addr_q;
    logic       pend_nack_q;

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN),
        .SYNC_LEN (SYNC_LEN)
    ) u_scl_filter (
        .clk       (clk),
        .reset     (reset),
        .raw_line  (scl),
        .filt_line (fscl)
    );

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN),
        .SYNC_LEN (SYNC_LEN)
    ) u_sda_filter (
        .clk       (clk),
        .reset     (reset),
        .raw_line  (sda),
        .filt_line (fsda)
    );

    // One-cycle delayed copies for edge detection; idle-high after reset so
    // a line that is already low is not mistaken for a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            fscl_d <= 1'b1;
            fsda_d <= 1'b1;
        end else begin
            fscl_d <= fscl;
            fsda_d <= fsda;
        end
    end

    assign scl_rise   = fscl & ~fscl_d;
    assign start_cond = fscl & fsda_d & ~fsda;
    assign stop_cond  = fscl & ~fsda_d & fsda;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // START/STOP take priority and restart framing, which silently drops any
    // partial byte. Clock edges in IDLE are ignored so that traffic caught
    // mid-transfer after reset never produces a byte.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        ack_en    = 1'b0;
        if (start_cond) begin
            state_d   = ADDR_BITS;
            bit_cnt_d = '0;
        end else if (stop_cond) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (scl_rise && (state_q != IDLE)) begin
            if (bit_cnt_q == ACK_BIT_IDX) begin
                ack_en    = 1'b1;
                bit_cnt_d = '0;
                state_d   = DATA_BITS;
            end else begin
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Shift data bits in MSB first; on the ACK clock stage the finished byte
    // for hand-off to the output register in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= 1'b0;
            pend_nack_q <= 1'b0;
        end else begin
            pend_q <= ack_en;
            if (shift_en) begin
                sreg_q <= {sreg_q[6:0], fsda};
            end
            if (ack_en) begin
                pend_data_q <= sreg_q;
                pend_addr_q <= (state_q == ADDR_BITS);
                pend_nack_q <= fsda;
            end
        end
    end

    // Single-entry output register. A pop and a load may share a cycle; a
    // byte that finds the register still full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_data  <= '0;
            byte_addr  <= 1'b0;
            byte_nack  <= 1'b0;
            byte_valid <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (pend_q) begin
                if (!byte_valid || byte_ready) begin
                    byte_data  <= pend_data_q;
                    byte_addr  <= pend_addr_q;
                    byte_nack  <= pend_nack_q;
                    byte_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor
// Self-checking bench for i2c_bus_monitor: table-driven transactions,
// hand-written corner cases (overrun, repeated START, glitch, reset
// mid-transfer) and randomised transactions against a byte-level model.
module tb_i2c_bus_monitor;

    localparam int HALF = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       addr;
        logic       nack;
    } byte_rec_t;

    typedef struct {
        logic [7:0] b0;
        logic       n0;
        logic [7:0] b1;
        logic       n1;
        int         nBytes;
        int         expCount;
        byte_rec_t  exp0;
        byte_rec_t  exp1;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda;
    logic [7:0] byte_data;
    logic       byte_addr;
    logic       byte_nack;
    logic       byte_valid;
    logic       byte_ready;
    logic       start_det;
    logic       stop_det;
    logic       overrun;

    int assertCount = 0;
    int failCount   = 0;
    int startCount  = 0;
    int stopCount   = 0;
    byte_rec_t gotQ[$];

    i2c_bus_monitor #(
        .FILT_LEN (3),
        .SYNC_LEN (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .byte_data  (byte_data),
        .byte_addr  (byte_addr),
        .byte_nack  (byte_nack),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe on the falling edge: pulses and accepted bytes.
    always @(negedge clk) begin
        if (!reset) begin
            if (start_det) startCount = startCount + 1;
            if (stop_det) stopCount = stopCount + 1;
            if (byte_valid && byte_ready) gotQ.push_back({byte_data, byte_addr, byte_nack});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2cStart();
        sda = 1'b1; waitCycles(HALF);
        scl = 1'b1; waitCycles(HALF);
        sda = 1'b0; waitCycles(HALF);
        scl = 1'b0; waitCycles(HALF);
    endtask

    task automatic i2cStop();
        sda = 1'b0; waitCycles(HALF);
        scl = 1'b1; waitCycles(HALF);
        sda = 1'b1; waitCycles(HALF);
    endtask

    task automatic i2cBit(input logic b);
        sda = b;    waitCycles(HALF);
        scl = 1'b1; waitCycles(HALF);
        scl = 1'b0; waitCycles(HALF);
    endtask

    task automatic i2cByte(input logic [7:0] data, input logic nack);
        for (int i = 7; i >= 0; i--) i2cBit(data[i]);
        i2cBit(nack);
    endtask

    task automatic resetDut();
        reset = 1'b1; scl = 1'b1; sda = 1'b1;
        waitCycles(4);
        reset = 1'b0;
        waitCycles(4);
    endtask

    task automatic applyStimulus(input vec_t v);
        i2cStart();
        i2cByte(v.b0, v.n0);
        if (v.nBytes > 1) i2cByte(v.b1, v.n1);
        i2cStop();
        waitCycles(HALF);
    endtask

    function automatic byte_rec_t gotAt(input int idx);
        byte_rec_t r;
        r = '0;
        if (idx < gotQ.size()) r = gotQ[idx];
        return r;
    endfunction

    initial begin
        vec_t vecs[4];
        int base;
        int s0;
        int p0;
        byte_rec_t expQ[$];
        byte_rec_t r;

        vecs[0] = '{8'hA0, 1'b0, 8'h3C, 1'b0, 2, 2, {8'hA0, 1'b1, 1'b0}, {8'h3C, 1'b0, 1'b0}};
        vecs[1] = '{8'h91, 1'b1, 8'h00, 1'b0, 1, 1, {8'h91, 1'b1, 1'b1}, {8'h00, 1'b0, 1'b0}};
        vecs[2] = '{8'hFF, 1'b0, 8'h00, 1'b1, 2, 2, {8'hFF, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b1}};
        vecs[3] = '{8'h01, 1'b0, 8'h80, 1'b1, 2, 2, {8'h01, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}};

        byte_ready = 1'b1;
        resetDut();

        // Reset state.
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, byte_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, byte_data}, 32'd0);
        checkOutput("rst_addr", {31'd0, byte_addr}, 32'd0);
        checkOutput("rst_nack", {31'd0, byte_nack}, 32'd0);
        checkOutput("rst_start", {31'd0, start_det}, 32'd0);
        checkOutput("rst_stop", {31'd0, stop_det}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        waitCycles(1);

        // Table-driven transactions, consumer always ready.
        for (int v = 0; v < 4; v++) begin
            base = gotQ.size(); s0 = startCount; p0 = stopCount;
            applyStimulus(vecs[v]);
            checkOutput($sformatf("vec%0d_count", v), gotQ.size() - base, vecs[v].expCount);
            checkOutput($sformatf("vec%0d_byte0", v), {22'd0, gotAt(base)}, {22'd0, vecs[v].exp0});
            if (vecs[v].expCount > 1)
                checkOutput($sformatf("vec%0d_byte1", v), {22'd0, gotAt(base + 1)}, {22'd0, vecs[v].exp1});
            checkOutput($sformatf("vec%0d_starts", v), startCount - s0, 1);
            checkOutput($sformatf("vec%0d_stops", v), stopCount - p0, 1);
            checkOutput($sformatf("vec%0d_overrun", v), {31'd0, overrun}, 32'd0);
        end

        // Repeated START after a partial byte: partial discarded.
        base = gotQ.size(); s0 = startCount;
        i2cStart();
        i2cByte(8'hA0, 1'b0);
        for (int i = 0; i < 4; i++) i2cBit(1'b1);
        i2cStart();
        i2cByte(8'hA1, 1'b0);
        i2cStop();
        waitCycles(HALF);
        checkOutput("rs_count", gotQ.size() - base, 2);
        checkOutput("rs_byte0", {22'd0, gotAt(base)}, {22'd0, 8'hA0, 1'b1, 1'b0});
        checkOutput("rs_byte1", {22'd0, gotAt(base + 1)}, {22'd0, 8'hA1, 1'b1, 1'b0});
        checkOutput("rs_starts", startCount - s0, 2);

        // Short scl glitch in a low phase.
        base = gotQ.size();
        i2cStart();
        for (int i = 7; i >= 0; i--) begin
            sda = 1'(8'h3C >> i);
            waitCycles(3);
            if (i == 5) begin
                scl = 1'b1; waitCycles(2);
                scl = 1'b0;
            end
            waitCycles(HALF);
            scl = 1'b1; waitCycles(HALF);
            scl = 1'b0; waitCycles(HALF);
        end
        i2cBit(1'b0);
        i2cStop();
        waitCycles(HALF);
        checkOutput("glitch_count", gotQ.size() - base, 1);
`ifdef I2C_MON_GLITCH_FILTER_EN
        checkOutput("glitch_byte", {22'd0, gotAt(base)}, {22'd0, 8'h3C, 1'b1, 1'b0});
`else
        checkOutput("glitch_byte", {22'd0, gotAt(base)}, {22'd0, 8'h3E, 1'b1, 1'b0});
`endif

        // Overrun: consumer stalled for three bytes.
        byte_ready = 1'b0;
        base = gotQ.size();
        i2cStart();
        i2cByte(8'hA0, 1'b0);
        checkOutput("ovr_valid", {31'd0, byte_valid}, 32'd1);
        checkOutput("ovr_overrun0", {31'd0, overrun}, 32'd0);
        i2cByte(8'h55, 1'b0);
        i2cByte(8'h66, 1'b0);
        @(negedge clk);
        checkOutput("ovr_held", {22'd0, byte_data, byte_addr, byte_nack}, {22'd0, 8'hA0, 1'b1, 1'b0});
        checkOutput("ovr_overrun1", {31'd0, overrun}, 32'd1);
        waitCycles(1);
        byte_ready = 1'b1;
        waitCycles(1);
        byte_ready = 1'b0;
        waitCycles(3);
        checkOutput("ovr_pops", gotQ.size() - base, 1);
        checkOutput("ovr_pop_byte", {22'd0, gotAt(base)}, {22'd0, 8'hA0, 1'b1, 1'b0});
        checkOutput("ovr_valid_after", {31'd0, byte_valid}, 32'd0);
        byte_ready = 1'b1;
        i2cStop();
        checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-byte, then ignore the rest of that transfer.
        i2cStart();
        i2cBit(1'b0); i2cBit(1'b1); i2cBit(1'b0);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mrst_outputs",
                    {20'd0, byte_data, byte_addr, byte_nack, byte_valid, start_det, stop_det, overrun},
                    32'd0);
        waitCycles(1);
        base = gotQ.size();
        i2cBit(1'b1); i2cBit(1'b0); i2cBit(1'b1); i2cBit(1'b0); i2cBit(1'b1);
        i2cBit(1'b0);
        i2cStop();
        waitCycles(HALF);
        checkOutput("mrst_ignored", gotQ.size() - base, 0);
        i2cStart();
        i2cByte(8'h42, 1'b0);
        i2cStop();
        waitCycles(HALF);
        checkOutput("mrst_count", gotQ.size() - base, 1);
        checkOutput("mrst_byte", {22'd0, gotAt(base)}, {22'd0, 8'h42, 1'b1, 1'b0});

        // Randomised transactions against a byte-level model.
        resetDut();
        for (int t = 0; t < 12; t++) begin
            int nb;
            int partial;
            logic rs;
            logic [7:0] d;
            logic n;
            expQ.delete();
            base = gotQ.size(); s0 = startCount;
            nb = int'($urandom_range(1, 4));
            partial = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            rs = 1'($urandom_range(0, 1));
            i2cStart();
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                n = 1'($urandom);
                i2cByte(d, n);
                expQ.push_back({d, (k == 0), n});
            end
            for (int k = 0; k < partial; k++) i2cBit(1'($urandom));
            if (rs) begin
                i2cStart();
                d = 8'($urandom);
                n = 1'($urandom);
                i2cByte(d, n);
                expQ.push_back({d, 1'b1, n});
            end
            i2cStop();
            waitCycles(HALF);
            checkOutput($sformatf("rnd%0d_count", t), gotQ.size() - base, expQ.size());
            for (int k = 0; k < expQ.size(); k++) begin
                r = gotAt(base + k);
                checkOutput($sformatf("rnd%0d_byte%0d", t, k), {22'd0, r}, {22'd0, expQ[k]});
            end
            checkOutput($sformatf("rnd%0d_starts", t), startCount - s0, rs ? 2 : 1);
        end
        checkOutput("rnd_overrun", {31'd0, overrun}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
